// File: rtl/timing_violation_arbiter_if.sv
// Event-stream bundle between the violation arbiter and its consumer.
// The arbiter side uses the master modport; the consumer/stimulus side uses slave.
interface timing_violation_arbiter_if #(
    parameter int N_MODULES  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
);
    localparam int ID_W  = $clog2(N_MODULES);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_MODULES-1:0] violation_flags;
    logic                 clear;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [ID_W-1:0]      evt_module_id;
    logic [TS_W-1:0]      evt_timestamp;
    logic [LVL_W-1:0]     evt_level;
    logic [N_MODULES-1:0] pending;
    logic [15:0]          drop_count;

    modport master (
        input  violation_flags, clear, evt_ready,
        output evt_valid, evt_module_id, evt_timestamp, evt_level, pending, drop_count
    );

    modport slave (
        output violation_flags, clear, evt_ready,
        input  evt_valid, evt_module_id, evt_timestamp, evt_level, pending, drop_count
    );
endinterface

// File: rtl/timing_violation_arbiter.sv
// Latches per-module violation pulses with a timestamp and serialises them through
// a round-robin arbiter into a show-ahead event FIFO drained over valid/ready.
module timing_violation_arbiter #(
    parameter int N_MODULES  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    timing_violation_arbiter_if.master   bus
);
    localparam int ID_W  = $clog2(N_MODULES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int CNT_W = $clog2(N_MODULES + 1);
    localparam int ENT_W = ID_W + TS_W;

    logic [TS_W-1:0]      ts;
    logic [ID_W-1:0]      rr_ptr;
    logic [N_MODULES-1:0] pending;
    logic [15:0]          drop_count;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;

    logic [TS_W-1:0]      ts_lat [N_MODULES];
    logic [ENT_W-1:0]     mem    [FIFO_DEPTH];

    logic                 evt_vld, pop, full;
    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W:0]        idx;
    logic [N_MODULES-1:0] gnt_onehot, cap, drop_vec, pending_nxt;
    logic [CNT_W-1:0]     drop_n;
    logic [ENT_W-1:0]     head;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CNT_W-1:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign evt_vld = (level != '0);
    assign pop     = evt_vld & bus.evt_ready;
    assign full    = (level == LVL_W'(FIFO_DEPTH));

    // Round-robin search starting at rr_ptr; a full FIFO may still accept when it pops.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < N_MODULES; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= (ID_W + 1)'(N_MODULES))
                idx = idx - (ID_W + 1)'(N_MODULES);
            if (!gnt_vld && pending[idx[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
        gnt_vld = gnt_vld & (!full | pop);
    end

    // A flag on a granted module re-arms it with the new timestamp instead of dropping.
    always_comb begin
        gnt_onehot = '0;
        drop_n     = '0;
        for (int i = 0; i < N_MODULES; i++)
            gnt_onehot[i] = gnt_vld && (gnt_id == ID_W'(i));
        cap         = bus.violation_flags & (~pending | gnt_onehot);
        drop_vec    = bus.violation_flags & pending & ~gnt_onehot;
        pending_nxt = cap | (pending & ~gnt_onehot);
        for (int i = 0; i < N_MODULES; i++)
            drop_n = drop_n + CNT_W'(drop_vec[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts         <= '0;
            rr_ptr     <= '0;
            pending    <= '0;
            drop_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (bus.clear) begin
                rr_ptr     <= '0;
                pending    <= '0;
                drop_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
            end else begin
                pending    <= pending_nxt;
                drop_count <= sat_add(drop_count, drop_n);
                if (gnt_vld) begin
                    rr_ptr <= (gnt_id == ID_W'(N_MODULES - 1)) ? '0 : gnt_id + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({gnt_vld, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    // Payload storage carries no reset; it is only observed through valid-qualified paths.
    always_ff @(posedge clk) begin
        if (!bus.clear) begin
            for (int i = 0; i < N_MODULES; i++)
                if (cap[i])
                    ts_lat[i] <= ts;
            if (gnt_vld)
                mem[wr_ptr] <= {gnt_id, ts_lat[gnt_id]};
        end
    end

    assign head              = mem[rd_ptr];
    assign bus.evt_valid     = evt_vld;
    assign bus.evt_module_id = evt_vld ? head[ENT_W-1:TS_W] : '0;
    assign bus.evt_timestamp = evt_vld ? head[TS_W-1:0] : '0;
    assign bus.evt_level     = level;
    assign bus.pending       = pending;
    assign bus.drop_count    = drop_count;
endmodule

// File: tb/tb_timing_violation_arbiter.sv
// Scoreboard bench for timing_violation_arbiter: expected events are queued as
// flags are driven and compared in order as the consumer accepts them.
module tb_timing_violation_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    timing_violation_arbiter_if bus ();

    timing_violation_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] ts;
    } evt_t;

    evt_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_ts;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) model_ts <= '0;
        else        model_ts <= model_ts + 16'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] f);
        bus.violation_flags = f;
        tick();
        bus.violation_flags = '0;
    endtask

    task automatic expect_evt(input int id, input logic [15:0] ts);
        evt_t e;
        e.id = 3'(id);
        e.ts = ts;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max);
        int c = 0;
        while ((exp_q.size() != 0 || bus.evt_level != '0 || bus.pending != '0) && c < max) begin
            tick();
            c++;
        end
        chk("drain_done", 32'(c < max), 32'd1);
    endtask

    // Consumer-side monitor: scoreboard pops on handshake, plus hold-under-backpressure.
    logic        hold_chk = 1'b0;
    logic        prev_clr = 1'b0;
    logic [2:0]  hold_id;
    logic [15:0] hold_ts;
    always @(negedge clk) begin
        evt_t e;
        if (rst_n) begin
            if (hold_chk && !prev_clr) begin
                chk("hold_valid", 32'(bus.evt_valid), 32'd1);
                chk("hold_id", 32'(bus.evt_module_id), 32'(hold_id));
                chk("hold_ts", 32'(bus.evt_timestamp), 32'(hold_ts));
            end
            if (bus.evt_valid && bus.evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_evt", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_id", 32'(bus.evt_module_id), 32'(e.id));
                    chk("evt_ts", 32'(bus.evt_timestamp), 32'(e.ts));
                end
            end
            hold_chk = bus.evt_valid && !bus.evt_ready;
            hold_id  = bus.evt_module_id;
            hold_ts  = bus.evt_timestamp;
            prev_clr = bus.clear;
        end else begin
            hold_chk = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t0, t1, t3;
        rst_n               = 1'b0;
        bus.violation_flags = '0;
        bus.clear           = 1'b0;
        bus.evt_ready       = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_id", 32'(bus.evt_module_id), 32'd0);
        chk("rst_ts", 32'(bus.evt_timestamp), 32'd0);
        chk("rst_level", 32'(bus.evt_level), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_drop", 32'(bus.drop_count), 32'd0);
        rst_n = 1'b1;

        // Single event at ts=10: grant next cycle, valid two cycles later, one cycle wide
        while (model_ts != 16'd10) tick();
        bus.violation_flags = 8'h04;
        expect_evt(2, 16'd10);
        @(negedge clk);
        chk("lat_t0_valid", 32'(bus.evt_valid), 32'd0);
        tick();
        bus.violation_flags = '0;
        @(negedge clk);
        chk("lat_t1_pending", 32'(bus.pending), 32'h04);
        chk("lat_t1_valid", 32'(bus.evt_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_t2_valid", 32'(bus.evt_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("lat_t3_valid", 32'(bus.evt_valid), 32'd0);
        tick();

        // Fairness from rr_ptr=0
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        t0 = model_ts;
        for (int i = 0; i < 8; i++) expect_evt(i, t0);
        pulse(8'hFF);
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fair_valid", 32'(bus.evt_valid), 32'd1);
            chk("fair_id", 32'(bus.evt_module_id), 32'(i));
            tick();
        end
        wait_drain(20);
        t0 = model_ts;
        expect_evt(1, t0);
        expect_evt(5, t0);
        pulse(8'h22);
        wait_drain(20);

        // Back-pressure: fill, latch one more, then drop a repeat
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_evt(k, model_ts);
            pulse(8'(1 << k));
        end
        tick();
        @(negedge clk);
        chk("full_level", 32'(bus.evt_level), 32'd8);
        chk("full_valid", 32'(bus.evt_valid), 32'd1);
        t3 = model_ts;
        expect_evt(3, t3);
        pulse(8'h08);
        @(negedge clk);
        chk("full_pending", 32'(bus.pending), 32'h08);
        chk("full_level_hold", 32'(bus.evt_level), 32'd8);
        chk("drop_before", 32'(bus.drop_count), 32'd0);
        pulse(8'h08);
        @(negedge clk);
        chk("drop_count_1", 32'(bus.drop_count), 32'd1);
        chk("drop_pending", 32'(bus.pending), 32'h08);
        bus.evt_ready = 1'b1;
        wait_drain(30);

        // Same-cycle grant and re-flag on module 0
        t0 = model_ts;
        bus.violation_flags = 8'h01;
        tick();
        t1 = model_ts;
        bus.violation_flags = 8'h01;
        tick();
        bus.violation_flags = '0;
        expect_evt(0, t0);
        expect_evt(0, t1);
        wait_drain(20);
        chk("regrant_drop", 32'(bus.drop_count), 32'd1);

        // Clear with 5 queued and pending=A0; flags in the clear cycle are discarded
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) pulse(8'(1 << k));
        tick();
        @(negedge clk);
        chk("pre_clr_level", 32'(bus.evt_level), 32'd5);
        bus.violation_flags = 8'hA0;
        tick();
        bus.violation_flags = 8'h01;
        bus.clear           = 1'b1;
        @(negedge clk);
        chk("pre_clr_pending", 32'(bus.pending), 32'hA0);
        chk("pre_clr_level5", 32'(bus.evt_level), 32'd5);
        tick();
        bus.clear           = 1'b0;
        bus.violation_flags = '0;
        @(negedge clk);
        chk("clr_level", 32'(bus.evt_level), 32'd0);
        chk("clr_pending", 32'(bus.pending), 32'd0);
        chk("clr_drop", 32'(bus.drop_count), 32'd0);
        chk("clr_valid", 32'(bus.evt_valid), 32'd0);
        chk("clr_id_xfree", 32'(bus.evt_module_id), 32'd0);
        bus.evt_ready = 1'b1;
        repeat (4) tick();
        chk("clr_stays_empty", 32'(bus.evt_valid), 32'd0);

        // Asynchronous reset mid-stream
        bus.evt_ready = 1'b0;
        pulse(8'h10);
        pulse(8'h40);
        tick();
        chk("pre_rst_level", 32'(bus.evt_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.evt_valid), 32'd0);
        chk("arst_level", 32'(bus.evt_level), 32'd0);
        chk("arst_pending", 32'(bus.pending), 32'd0);
        chk("arst_id", 32'(bus.evt_module_id), 32'd0);
        chk("arst_ts", 32'(bus.evt_timestamp), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        expect_evt(4, 16'h0000);
        pulse(8'h10);
        wait_drain(20);

        // Timestamp wrap
        while (model_ts != 16'hFFFF) tick();
        expect_evt(6, 16'hFFFF);
        bus.violation_flags = 8'h40;
        tick();
        expect_evt(1, 16'h0000);
        bus.violation_flags = 8'h02;
        tick();
        bus.violation_flags = '0;
        wait_drain(20);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timing_violation_arbiter.md
# timing_violation_arbiter

Controller that sequences per-module timing-violation events from the timing-check submodules into an ordered event stream for firmware and the testbench scoreboard. It latches each module's violation pulse with a timestamp and shares a single event FIFO among the N_MODULES requesters using round-robin arbitration. It drains the FIFO over a valid/ready interface, counts events lost to back-pressure, and sits beside the violation-count aggregator at the timing-check hierarchy top.

## Interface
- N_MODULES, 8: number of violation sources; range 2..16.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TS_W, 16: timestamp width.

- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- violation_flags  in  N_MODULES  one-cycle violation pulse per module.
- clear  in  1  synchronous soft clear, single-cycle pulse.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head when evt_valid is high.
- evt_module_id  out  $clog2(N_MODULES)  source module of head event.
- evt_timestamp  out  TS_W  timestamp of head event.
- evt_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- pending  out  N_MODULES  latched, not-yet-queued violations.
- drop_count  out  16  saturating count of lost events.

## Operation
- Timestamp counter ts: free-running, +1 every cycle, wraps 2^TS_W−1→0. It is not affected by clear.
- Capture: if violation_flags[i]=1 in cycle t, then pending[i] is set at t+1 and ts_lat[i] = ts(t).
- Drop: a flag arrives while pending[i]=1 and module i is not granted in that cycle. pending[i] and ts_lat[i] are kept (oldest wins), and drop_count increments, saturating at 0xFFFF. Multiple drops in one cycle add their count, also saturating.
- Arbiter grants when pending≠0 and the FIFO is not full, or is full but popping this cycle.
  - Grant goes to the first set pending index at or after rr_ptr, wrapping at N_MODULES.
  - On grant: push {i, ts_lat[i]}, clear pending[i], and set rr_ptr ← (i+1) mod N_MODULES.
  - One grant per cycle at most.
- Same-cycle grant of i and a new flag on i: the granted entry uses the old ts_lat. pending[i] is re-set with the new timestamp. No drop is counted.
- FIFO: show-ahead. The head is driven combinationally from the storage at the read pointer. A pop occurs when evt_valid & evt_ready. Push and pop in the same cycle leave the level unchanged.
- Full: no grant, and pending bits hold. A push while full never occurs.
- Empty: evt_valid=0. evt_module_id and evt_timestamp are don't-care, but must be X-free.
- clear, synchronous, takes priority over everything:
  - Next cycle: FIFO empty, pending=0, drop_count=0, rr_ptr=0.
  - Flags and pops in the clear cycle are discarded.
- Asynchronous reset mid-operation discards all state immediately.

## Timing
- Reset values: evt_valid=0, evt_module_id=0, evt_timestamp=0, evt_level=0, pending=0, drop_count=0. Internally, ts=0 and rr_ptr=0.
- Latency is 2 cycles from pulse to event. A flag in cycle t with an idle arbiter and non-full FIFO gives a grant in t+1 and evt_valid=1 in t+2.
- N simultaneous flags drain at one event per cycle, in round-robin order.
- Handshake:
  - evt_module_id and evt_timestamp hold stable while evt_valid=1 and evt_ready=0.
  - evt_valid may not drop without a pop or clear.
- drop_count, pending and evt_level are registered, valid the cycle after their cause.

## Test plan
- Reset: assert rst_n=0 mid-stream → all outputs take reset values asynchronously. After release, ts counts from 0.
- Single event: with evt_ready=1, violation_flags=8'h04 in cycle 10 (ts=10) → evt_valid in cycle 12 with module_id=2, timestamp=10, and a single-cycle valid.
- Fairness:
  - All 8 flags at once, rr_ptr=0 → ids 0..7 on consecutive cycles.
  - Then flags {1,5} with rr_ptr=0 → order 1, 5.
- Back-pressure and drop: evt_ready=0 with 8 distinct events → FIFO full, evt_level=8.
  - A further flag on module 3 gives pending[3]=1.
  - A second flag on module 3 gives drop_count=1.
  - Raise evt_ready → module 3's event carries the first timestamp.
- Same-cycle grant and re-flag on module 0 → two events for module 0 with distinct timestamps and drop_count unchanged.
- Clear with FIFO at 5 entries and pending=8'hA0 → next cycle evt_level=0, pending=0, drop_count=0.
- Timestamp wrap: an event at ts=16'hFFFF is followed by one at ts=0, with the timestamps reported accordingly.
